// File: rtl/demod_pkg.sv
// Shared types, widths and the frame-head magnitude test for the QPSK demod sequencer.
package demod_pkg;

  localparam int unsigned SAMPLE_W  = 9;
  localparam int unsigned SYM_IDX_W = 5;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Sample magnitude strictly above thr on either polarity; also used as the carrier-present test.
  function automatic logic is_head(input logic [SAMPLE_W-1:0] x, input logic [7:0] thr);
    logic [8:0] mag;
    logic [8:0] thr9;
    mag  = {1'b0, x[7:0]};
    thr9 = {1'b0, thr};
    return (!x[8] && (mag > thr9)) || (x[8] && (mag < (9'd256 - thr9)));
  endfunction

endpackage

// File: rtl/sample_strobe_gen.sv
// Clock divider producing a strobe on the last count of each SAMPLE_DIV-clock period.
module sample_strobe_gen #(
  parameter int unsigned SAMPLE_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic strobe_c
);

  localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(SAMPLE_DIV - 1);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign strobe_c = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/demod_frame_sequencer.sv
// Frame timing sequencer for the coherent QPSK demod datapath (head hunt, sample strobes, symbol dumps).
// Optional carrier-loss abort is built when CARRIER_LOSS_EN is defined.
module demod_frame_sequencer
  import demod_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV      = 4,
  parameter int unsigned SAMPLES_PER_SYM = 32,
  parameter int unsigned SYMS_PER_FRAME  = 32,
  parameter int unsigned DET_THRESH      = 60,
`ifdef CARRIER_LOSS_EN
  parameter int unsigned LOSS_LEN        = 64,
`endif
  parameter int unsigned LUT_AW          = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [SAMPLE_W-1:0]  channel_out,
  input  logic                 sym_ready,
  output logic                 sample_en,
  output logic [LUT_AW-1:0]    lut_addr,
  output logic                 acc_clr,
  output logic                 acc_en,
  output logic                 dump,
  output logic [SYM_IDX_W-1:0] sym_idx,
  output logic                 frame_active,
  output logic                 frame_done,
  output logic                 overrun
`ifdef CARRIER_LOSS_EN
  ,
  output logic                 carrier_lost
`endif
);

  localparam int unsigned SC_W = $clog2(SAMPLES_PER_SYM + 1);

  state_e                 state_q, state_d;
  logic [SC_W-1:0]        samp_cnt_q, samp_cnt_d;
  logic [LUT_AW-1:0]      lut_addr_q, lut_addr_d;
  logic [SYM_IDX_W-1:0]   sym_idx_q, sym_idx_d;
  logic                   sample_en_q, sample_en_d;
  logic                   acc_clr_q, acc_clr_d;
  logic                   acc_en_q, acc_en_d;
  logic                   dump_q, dump_d;
  logic                   frame_active_q, frame_active_d;
  logic                   frame_done_q, frame_done_d;
  logic                   overrun_q, overrun_d;
  logic                   strobe_c;
  logic                   head_c;
`ifdef CARRIER_LOSS_EN
  localparam int unsigned LC_W = $clog2(LOSS_LEN + 1);
  logic [LC_W-1:0]        loss_cnt_q, loss_cnt_d;
  logic                   carrier_lost_q, carrier_lost_d;
`endif

  // Divider only runs in RUN, so it always restarts from zero on a detect.
  sample_strobe_gen #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_strobe (
    .clk      (clk),
    .reset    (reset),
    .clr      (state_q != RUN),
    .en       (state_q == RUN),
    .strobe_c (strobe_c)
  );

  assign head_c = is_head(channel_out, 8'(DET_THRESH));

  always_comb begin
    state_d        = state_q;
    samp_cnt_d     = samp_cnt_q;
    lut_addr_d     = lut_addr_q;
    sym_idx_d      = sym_idx_q;
    sample_en_d    = 1'b0;
    acc_clr_d      = 1'b0;
    acc_en_d       = 1'b0;
    dump_d         = 1'b0;
    frame_active_d = 1'b0;
    frame_done_d   = 1'b0;
    overrun_d      = overrun_q | (dump_q & ~sym_ready);
`ifdef CARRIER_LOSS_EN
    loss_cnt_d     = loss_cnt_q;
    carrier_lost_d = 1'b0;
`endif
    if (!enable) begin
      state_d    = HUNT;
      samp_cnt_d = '0;
      lut_addr_d = '0;
      sym_idx_d  = '0;
      overrun_d  = 1'b0;
`ifdef CARRIER_LOSS_EN
      loss_cnt_d = '0;
`endif
    end else begin
      case (state_q)
        HUNT: begin
          if (head_c) begin
            state_d        = RUN;
            acc_clr_d      = 1'b1;
            frame_active_d = 1'b1;
            samp_cnt_d     = SC_W'(1);
            lut_addr_d     = '0;
            sym_idx_d      = '0;
`ifdef CARRIER_LOSS_EN
            loss_cnt_d     = '0;
`endif
          end
        end
        RUN: begin
          frame_active_d = 1'b1;
          if (strobe_c) begin
            sample_en_d = 1'b1;
            if (samp_cnt_q < SC_W'(SAMPLES_PER_SYM)) begin
              acc_en_d   = 1'b1;
              samp_cnt_d = samp_cnt_q + SC_W'(1);
              lut_addr_d = lut_addr_q + LUT_AW'(1);
            end else begin
              dump_d     = 1'b1;
              acc_clr_d  = 1'b1;
              samp_cnt_d = SC_W'(1);
              lut_addr_d = '0;
              if (sym_idx_q == SYM_IDX_W'(SYMS_PER_FRAME - 1)) begin
                state_d        = DONE;
                frame_active_d = 1'b0;
              end else begin
                sym_idx_d = sym_idx_q + SYM_IDX_W'(1);
              end
            end
`ifdef CARRIER_LOSS_EN
            // A failing sample on the LOSS_LEN-th strobe overrides whatever this strobe would do.
            if (head_c) begin
              loss_cnt_d = '0;
            end else if (loss_cnt_q == LC_W'(LOSS_LEN - 1)) begin
              state_d        = HUNT;
              carrier_lost_d = 1'b1;
              sample_en_d    = 1'b0;
              acc_en_d       = 1'b0;
              acc_clr_d      = 1'b0;
              dump_d         = 1'b0;
              frame_active_d = 1'b0;
              loss_cnt_d     = '0;
            end else begin
              loss_cnt_d = loss_cnt_q + LC_W'(1);
            end
`endif
          end
        end
        DONE: begin
          frame_done_d = 1'b1;
          state_d      = HUNT;
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= HUNT;
      samp_cnt_q     <= '0;
      lut_addr_q     <= '0;
      sym_idx_q      <= '0;
      sample_en_q    <= 1'b0;
      acc_clr_q      <= 1'b0;
      acc_en_q       <= 1'b0;
      dump_q         <= 1'b0;
      frame_active_q <= 1'b0;
      frame_done_q   <= 1'b0;
      overrun_q      <= 1'b0;
`ifdef CARRIER_LOSS_EN
      loss_cnt_q     <= '0;
      carrier_lost_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      samp_cnt_q     <= samp_cnt_d;
      lut_addr_q     <= lut_addr_d;
      sym_idx_q      <= sym_idx_d;
      sample_en_q    <= sample_en_d;
      acc_clr_q      <= acc_clr_d;
      acc_en_q       <= acc_en_d;
      dump_q         <= dump_d;
      frame_active_q <= frame_active_d;
      frame_done_q   <= frame_done_d;
      overrun_q      <= overrun_d;
`ifdef CARRIER_LOSS_EN
      loss_cnt_q     <= loss_cnt_d;
      carrier_lost_q <= carrier_lost_d;
`endif
    end
  end

  assign sample_en    = sample_en_q;
  assign lut_addr     = lut_addr_q;
  assign acc_clr      = acc_clr_q;
  assign acc_en       = acc_en_q;
  assign dump         = dump_q;
  assign sym_idx      = sym_idx_q;
  assign frame_active = frame_active_q;
  assign frame_done   = frame_done_q;
  assign overrun      = overrun_q;
`ifdef CARRIER_LOSS_EN
  assign carrier_lost = carrier_lost_q;
`endif

endmodule
